reg_logic_pipe: RTL and testbench

Parametrised, pipelined bitwise logic unit. It computes a selectable two-operand function (AND, OR, XOR, NOR) over WIDTH-bit operands and registers the result through STAGES pipeline stages with valid/ready flow control on both sides. It also counts delivered results. It succeeds the single-bit combinational gate blocks and is the building block for multi-bit logic datapaths in the examples tree.

---
 rtl/reg_logic_pipe.sv | 95 +++++++++
 tb/tb_reg_logic_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_logic_pipe.sv
// Pipelined WIDTH-bit logic unit (AND/OR/XOR/NOR) with valid/ready flow control and a delivery counter.
// Optional registered even-parity output is enabled by defining REG_LOGIC_PIPE_PARITY_EN.
module reg_logic_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_q,
  output logic [15:0]      o_count
`ifdef REG_LOGIC_PIPE_PARITY_EN
  ,
  output logic             o_parity
`endif
);

  function automatic logic [WIDTH-1:0] f_logic(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [1:0]       op);
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = ~(a | b);
    endcase
    return r;
  endfunction

  logic [STAGES-1:0] r_vld;
  logic [WIDTH-1:0]  r_dat [STAGES];
  logic [STAGES-1:0] w_load;
  logic [WIDTH-1:0]  w_fn;
  logic [15:0]       r_count;

  assign w_fn = f_logic(i_a, i_b, i_op);

  // Stage k loads when any stage from k to the output is empty or the sink is taking data;
  // written in closed form to keep the backward ripple free of self-referencing vectors.
  for (genvar k = 0; k < STAGES; k++) begin : g_load
    assign w_load[k] = i_ready | ~(&r_vld[STAGES-1:k]);
  end

  assign o_ready = w_load[0];
  assign o_valid = r_vld[STAGES-1];
  assign o_q     = r_dat[STAGES-1];
  assign o_count = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
    end else begin
      if (w_load[0]) r_vld[0] <= i_valid;
      for (int k = 1; k < STAGES; k++) begin
        if (w_load[k]) r_vld[k] <= r_vld[k-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_load[0]) r_dat[0] <= w_fn;
    for (int k = 1; k < STAGES; k++) begin
      if (w_load[k]) r_dat[k] <= r_dat[k-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= 16'd0;
    end else if (o_valid && i_ready) begin
      r_count <= r_count + 16'd1;
    end
  end

`ifdef REG_LOGIC_PIPE_PARITY_EN
  logic [STAGES-1:0] r_par;

  always_ff @(posedge i_clk) begin
    if (w_load[0]) r_par[0] <= ^w_fn;
    for (int k = 1; k < STAGES; k++) begin
      if (w_load[k]) r_par[k] <= r_par[k-1];
    end
  end

  assign o_parity = r_par[STAGES-1];
`endif

endmodule

// File: tb/tb_reg_logic_pipe.sv
// Directed scoreboard bench for reg_logic_pipe (WIDTH=8, STAGES=2).
// Parity checks are compiled in when REG_LOGIC_PIPE_PARITY_EN is defined.
module tb_reg_logic_pipe;
  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

  logic             clk = 1'b0;
  logic             i_rst_n;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic [1:0]       i_op;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_q;
  logic [15:0]      o_count;
`ifdef REG_LOGIC_PIPE_PARITY_EN
  logic             o_parity;
`endif

  reg_logic_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .i_clk   (clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_op    (i_op),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_q     (o_q),
    .o_count (o_count)
`ifdef REG_LOGIC_PIPE_PARITY_EN
    ,
    .o_parity(o_parity)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] d;
    int               t;
  } exp_t;

  exp_t sb_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   exp_count = 0;
  int   delivered = 0;
  bit   lat_chk   = 1'b0;

  logic             s_ready;
  logic             s_valid;
  logic [WIDTH-1:0] s_q;
  bit               s_acc;

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [1:0] op);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (op)
        2'b00:   r[i] = a[i] && b[i];
        2'b01:   r[i] = a[i] || b[i];
        2'b10:   r[i] = a[i] != b[i];
        default: r[i] = !(a[i] || b[i]);
      endcase
    end
    return r;
  endfunction

  task automatic chk_bit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock: drive, sample at negedge, score, advance to posedge+1.
  task automatic step(input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [1:0] op, input bit rdy);
    exp_t e;
    i_valid = v; i_a = a; i_b = b; i_op = op; i_ready = rdy;
    @(negedge clk);
    s_ready = o_ready;
    s_valid = o_valid;
    s_q     = o_q;
    s_acc   = v && o_ready;
    if (o_valid === 1'b1 && rdy) begin
      chk_int("sb_nonempty", (sb_q.size() > 0) ? 1 : 0, 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        assert (o_q === e.d) else begin
          failures++;
          $error("FAIL out_data observed=%02h expected=%02h", o_q, e.d);
        end
        if (lat_chk) chk_int("latency", cyc - e.t, STAGES);
`ifdef REG_LOGIC_PIPE_PARITY_EN
        chk_bit("parity", o_parity, ^e.d);
`endif
      end
      exp_count++;
      delivered++;
    end
    if (s_acc) begin
      e.d = model(a, b, op);
      e.t = cyc;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) step(1'b0, '0, '0, 2'b00, 1'b1);
    chk_int(tag, sb_q.size(), 0);
  endtask

  initial begin
    logic [WIDTH-1:0] bp_data [6];
    logic [1:0]       ops     [4];
    int               idx;
    int               d0;

    i_rst_n = 1'b0; i_valid = 1'b0; i_a = '0; i_b = '0; i_op = 2'b00; i_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_bit("rst_valid", o_valid, 1'b0);
    chk_bit("rst_ready", o_ready, 1'b1);
    chk_int("rst_count", int'(o_count), 0);
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Operation coverage with an always-ready sink.
    lat_chk = 1'b1;
    ops[0] = 2'b00; ops[1] = 2'b01; ops[2] = 2'b10; ops[3] = 2'b11;
    for (int i = 0; i < 4; i++) step(1'b1, 8'hF0, 8'h3C, ops[i], 1'b1);
    drain("ops_drain");
    lat_chk = 1'b0;
    chk_bit("op_and", model(8'hF0, 8'h3C, 2'b00) == 8'h30, 1'b1);
    chk_int("count_ops", int'(o_count), exp_count);

    // Back-pressure: five stalled cycles, then release.
    for (int i = 0; i < 6; i++) bp_data[i] = 8'(i + 1);
    idx = 0;
    d0  = delivered;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, bp_data[idx], 8'h00, 2'b01, 1'b0);
      if (s_acc) idx++;
      if (c >= 2) begin
        chk_bit("bp_ready_low", s_ready, 1'b0);
        chk_bit("bp_valid", s_valid, 1'b1);
        checks++;
        assert (s_q === 8'h01) else begin
          failures++;
          $error("FAIL bp_hold observed=%02h expected=01", s_q);
        end
      end
    end
    chk_int("bp_accepts", idx, 2);
    for (int c = 0; c < 30 && (idx < 6 || sb_q.size() > 0); c++) begin
      if (idx < 6) begin
        step(1'b1, bp_data[idx], 8'h00, 2'b01, 1'b1);
        if (s_acc) idx++;
      end else begin
        step(1'b0, '0, '0, 2'b00, 1'b1);
      end
    end
    chk_int("bp_delivered", delivered - d0, 6);
    chk_int("bp_sb_empty", sb_q.size(), 0);

    // Bubble collapse with a stalled sink.
    step(1'b1, 8'hA5, 8'h0F, 2'b10, 1'b0);
    chk_bit("bub_acc1", s_acc, 1'b1);
    step(1'b0, '0, '0, 2'b00, 1'b0);
    step(1'b1, 8'h5A, 8'hFF, 2'b00, 1'b0);
    chk_bit("bub_acc2", s_acc, 1'b1);
    step(1'b0, '0, '0, 2'b00, 1'b0);
    chk_bit("bub_ready_low", s_ready, 1'b0);
    chk_bit("bub_valid", s_valid, 1'b1);
    drain("bub_drain");
    chk_int("count_bub", int'(o_count), exp_count);

`ifdef REG_LOGIC_PIPE_PARITY_EN
    step(1'b1, 8'h07, 8'h00, 2'b01, 1'b0);
    step(1'b1, 8'h03, 8'h00, 2'b01, 1'b0);
    step(1'b0, '0, '0, 2'b00, 1'b0);
    chk_bit("par_07", o_parity, 1'b1);
    step(1'b0, '0, '0, 2'b00, 1'b1);
    chk_bit("par_03", o_parity, 1'b0);
    drain("par_drain");
`endif

    // Reset with two results in flight.
    step(1'b1, 8'h11, 8'h22, 2'b01, 1'b0);
    step(1'b1, 8'h33, 8'h44, 2'b01, 1'b0);
    i_rst_n = 1'b0;
    #1;
    chk_bit("mid_rst_valid", o_valid, 1'b0);
    chk_bit("mid_rst_ready", o_ready, 1'b1);
    chk_int("mid_rst_count", int'(o_count), 0);
    sb_q.delete();
    exp_count = 0;
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(1'b0, '0, '0, 2'b00, 1'b1);
      chk_bit("no_stale", s_valid, 1'b0);
    end
    lat_chk = 1'b1;
    step(1'b1, 8'hC3, 8'h81, 2'b00, 1'b1);
    drain("post_rst_drain");
    lat_chk = 1'b0;
    chk_int("count_post_rst", int'(o_count), 1);

    // Counter wrap: 65537 handshakes since a fresh reset.
    i_rst_n = 1'b0;
    #1;
    sb_q.delete();
    exp_count = 0;
    d0 = delivered;
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    for (int c = 0; c < 65600 && (delivered - d0) < 65537; c++) begin
      step(1'b1, 8'(c), 8'($urandom), 2'($urandom), 1'b1);
      if ((delivered - d0) == 65536) chk_int("count_wrap0", int'(o_count), 0);
    end
    chk_int("wrap_handshakes", delivered - d0, 65537);
    chk_int("count_wrap1", int'(o_count), 1);
    chk_int("count_model", int'(o_count), exp_count % 65536);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
